hex_uart_tx: RTL and testbench

HEX_UART_TX -- requirements
Module: hex_uart_tx

---
 rtl/hex_uart_tx.sv | 155 +++++++++++++++
 tb/tb_hex_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_uart_tx.sv
// Nibble-to-ASCII-hex UART transmitter: 8N1 frames, LSB first, idle-high line.
// Define HEX_UART_PARITY_EN to add an even-parity bit between the data and stop bits.
module hex_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

`ifdef HEX_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [IDX_W-1:0] bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             tx_d, busy_d, ready_d;
  logic             bit_done;

  // Map a nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) res = 8'h30 + {4'h0, nib};
    else             res = 8'h37 + {4'h0, nib};
    return res;
  endfunction

  assign bit_done = (baud_cnt == CNT_LAST);

  // Next-state, counters and registered-output precomputation.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    ready_d    = 1'b1;

    case (state)
      IDLE: begin
        if (valid_in && ready_out) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          shreg_d    = to_ascii(data_in);
        end
      end
      START: begin
        if (bit_done) begin
          state_d    = DATA;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) begin
`ifdef HEX_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`ifdef HEX_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase

    // Outputs are registered from the upcoming state so the line moves one cycle after acceptance.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_idx_d];
`ifdef HEX_UART_PARITY_EN
      PARITY:  tx_d = ^shreg_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_out    <= 1'b1;
      busy_out  <= 1'b0;
      ready_out <= 1'b1;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      tx_out    <= tx_d;
      busy_out  <= busy_d;
      ready_out <= ready_d;
    end
  end

endmodule

// File: tb/tb_hex_uart_tx.sv
// Scoreboard bench for hex_uart_tx: stimulus queues expected characters, a UART
// receiver process decodes tx_out and checks bytes, bit timing, latency and gaps.
module tb_hex_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef HEX_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic       valid_in = 1'b0;
  logic       ready_out, tx_out, busy_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int idle_run = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         gap;
  } exp_t;
  exp_t exp_q[$];

  hex_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx_out   (tx_out),
    .busy_out (busy_out)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endfunction

  // Reference: the character a terminal would show for this nibble.
  function automatic logic [7:0] model(input logic [3:0] nib);
    string hex;
    hex = "0123456789ABCDEF";
    return hex[int'(nib)];
  endfunction

  // Wait (bounded) until the held valid_in is accepted; acc = cycle of the accepting edge.
  task automatic wait_accept(output int acc);
    int n;
    logic r;
    int c;
    n = 0;
    acc = -1;
    while (n <= TMO) begin
      @(negedge clk);
      r = ready_out;
      c = cyc;
      @(posedge clk);
      #1;
      if (r) begin
        acc = c;
        break;
      end
      n++;
    end
    chk("accept_timeout", (acc < 0) ? 1 : 0, 0);
  endtask

  task automatic send(input logic [3:0] nib, input int gap, output int acc);
    data_in  = nib;
    valid_in = 1'b1;
    wait_accept(acc);
    if (acc >= 0) exp_q.push_back('{model(nib), acc, gap});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_out) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n >= TMO) ? 1 : 0, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: UART receiver that also checks each bit is held exactly CPB cycles.
  initial begin : monitor
    logic [NB-1:0] bits;
    bit   abort, glitch, hs;
    int   start_c, gap;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 0;
        continue;
      end
      if (tx_out) begin
        idle_run++;
        continue;
      end
      start_c = cyc;
      gap     = idle_run + int'(CPB);
      abort   = 0;
      glitch  = 0;
      hs      = 0;
      bits    = '0;
      for (int b = 0; b < NB && !abort; b++) begin
        for (int c = 0; c < int'(CPB); c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rst_n) begin
            abort = 1;
            break;
          end
          if (c == 0) bits[b] = tx_out;
          else if (tx_out !== bits[b]) glitch = 1;
          if (busy_out !== 1'b1 || ready_out !== 1'b0) hs = 1;
        end
      end
      if (abort) begin
        idle_run = 0;
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", int'(bits[8:1]), -1);
      end else begin
        e = exp_q.pop_front();
        chk("byte", int'(bits[8:1]), int'(e.data));
        chk("start_bit", int'(bits[0]), 0);
        chk("stop_bit", int'(bits[NB-1]), 1);
`ifdef HEX_UART_PARITY_EN
        chk("parity_bit", int'(bits[9]), $countones(e.data) % 2);
`endif
        chk("bit_width", int'(glitch), 0);
        chk("busy_ready_in_frame", int'(hs), 0);
        chk("start_latency", start_c, e.acc + 1);
        if (e.gap >= 0) chk("frame_gap", gap, e.gap);
      end
      @(negedge clk);
      if (rst_n) begin
        chk("idle_after_frame", int'({ready_out, busy_out, tx_out}), 5);
        idle_run = tx_out ? 1 : 0;
      end else begin
        idle_run = 0;
      end
    end
  end

  initial begin : stimulus
    int  acc, rel;
    bit  keep;
    logic [3:0] nib;

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_tx", int'(tx_out), 1);
    chk("reset_busy", int'(busy_out), 0);
    chk("reset_ready", int'(ready_out), 1);
    repeat (2) @(posedge clk);
    #1;

    // Release reset and request in the same cycle: the first edge must accept.
    rst_n = 1'b1;
    rel   = cyc;
    send(4'h5, -1, acc);
    chk("first_edge_accept", acc, rel);
    valid_in = 1'b0;
    drain();

    foreach (exp_q[i]) exp_q.delete(i);
    send(4'hA, -1, acc); valid_in = 1'b0; drain();
    send(4'hF, -1, acc); valid_in = 1'b0; drain();
    send(4'h7, -1, acc); valid_in = 1'b0; drain();
    send(4'h0, -1, acc); valid_in = 1'b0; drain();

    // valid_in held across frames: one IDLE cycle between them.
    send(4'h1, -1, acc);
    send(4'h2, int'(CPB) + 1, acc);
    valid_in = 1'b0;
    drain();

    // Input churn during a frame must not disturb it.
    send(4'h9, -1, acc);
    for (int i = 0; i < 36; i++) begin
      data_in  = (i % 2 == 0) ? 4'h0 : 4'hF;
      valid_in = (i % 2 == 1);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    drain();

    // Reset in cycle 17 of a frame.
    send(4'h6, -1, acc);
    valid_in = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_tx", int'(tx_out), 1);
    chk("midreset_busy", int'(busy_out), 0);
    chk("midreset_ready", int'(ready_out), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'h3, -1, acc);
    valid_in = 1'b0;
    drain();

    // Randomized nibbles with random back-to-back holds and idle spacing.
    keep = 0;
    for (int i = 0; i < 24; i++) begin
      nib = 4'($urandom_range(15));
      send(nib, keep ? int'(CPB) + 1 : -1, acc);
      keep = ($urandom_range(1) == 1);
      if (!keep) begin
        valid_in = 1'b0;
        data_in  = 4'($urandom_range(15));
        repeat ($urandom_range(50)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    valid_in = 1'b0;
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
